// File: rtl/tf_delay_line_if.sv
// Bundle of the twiddle delay-line stream, control and status signals.
// The master side feeds twiddles/modulus and control; the slave side is the
// delay line itself.
interface tf_delay_line_if #(
    parameter int NUM_CH = 16,
    parameter int DW     = 16,
    parameter int CW     = 4
);
    logic                   in_valid;
    logic [NUM_CH*DW-1:0]   tf_in;
    logic [DW-1:0]          mod_in;
    logic                   stall;
    logic                   flush;
    logic                   cfg_we;
    logic [CW-1:0]          delay_cfg;
    logic                   out_valid;
    logic [NUM_CH*DW-1:0]   tf_out;
    logic [DW-1:0]          mod_out;
    logic                   busy;
    logic [CW-1:0]          active_delay;
    logic                   cfg_err;

    modport master (
        output in_valid, tf_in, mod_in, stall, flush, cfg_we, delay_cfg,
        input  out_valid, tf_out, mod_out, busy, active_delay, cfg_err
    );

    modport slave (
        input  in_valid, tf_in, mod_in, stall, flush, cfg_we, delay_cfg,
        output out_valid, tf_out, mod_out, busy, active_delay, cfg_err
    );
endinterface

// File: rtl/tf_delay_line.sv
// Multi-channel twiddle-factor delay line. Holds MAX_DEPTH stages of
// {valid, twiddles, modulus} and taps the stage selected by active_delay,
// or bypasses combinationally when the delay is zero. The delay can only be
// changed while the pipe is empty and not stalled, so no stale entry can
// ever appear at a new tap.
`ifndef D_width
`define D_width 16
`endif

module tf_delay_line #(
    parameter int NUM_CH        = 16,
    parameter int DW            = `D_width,
    parameter int MAX_DEPTH     = 8,
    parameter int DEFAULT_DELAY = 3,
    parameter int CW            = $clog2(MAX_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    tf_delay_line_if.slave bus
);

    localparam int TW = NUM_CH * DW;

    // Clamp a requested delay to the physical depth.
    function automatic logic [CW-1:0] clamp_delay(input logic [CW-1:0] req);
        logic [CW-1:0] res;
        if (req > CW'(MAX_DEPTH)) begin
            res = CW'(MAX_DEPTH);
        end else begin
            res = req;
        end
        return res;
    endfunction

    logic [MAX_DEPTH-1:0] valid_r;
    logic [TW-1:0]        tf_r  [MAX_DEPTH];
    logic [DW-1:0]        mod_r [MAX_DEPTH];
    logic [CW-1:0]        active_delay_r;
    logic                 cfg_err_r;

    logic                 busy_s;
    logic                 advance_s;
    logic                 cfg_ok_s;
    logic                 cfg_over_s;
    logic                 tap_valid_s;
    logic [TW-1:0]        tap_tf_s;
    logic [DW-1:0]        tap_mod_s;
    logic                 out_valid_s;
    logic [TW-1:0]        tf_out_s;
    logic [DW-1:0]        mod_out_s;

    assign busy_s     = |valid_r;
    assign advance_s  = ~bus.stall & ~bus.flush;
    // Acceptance uses the busy value seen before any flush on the same edge.
    assign cfg_ok_s   = ~busy_s & ~bus.stall;
    assign cfg_over_s = (bus.delay_cfg > CW'(MAX_DEPTH));

    // Valid bits: cleared by flush, shifted on advance, held on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (bus.flush) begin
            valid_r <= '0;
        end else if (advance_s) begin
            valid_r[0] <= bus.in_valid;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Data stages: shift on advance only; flush leaves the data untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                tf_r[k]  <= '0;
                mod_r[k] <= '0;
            end
        end else if (advance_s) begin
            tf_r[0]  <= bus.tf_in;
            mod_r[0] <= bus.mod_in;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                tf_r[k]  <= tf_r[k-1];
                mod_r[k] <= mod_r[k-1];
            end
        end else begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                tf_r[k]  <= tf_r[k];
                mod_r[k] <= mod_r[k];
            end
        end
    end

    // Guarded delay reconfiguration and the one-cycle error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_delay_r <= CW'(DEFAULT_DELAY);
            cfg_err_r      <= 1'b0;
        end else if (bus.cfg_we) begin
            if (cfg_ok_s) begin
                active_delay_r <= clamp_delay(bus.delay_cfg);
                cfg_err_r      <= cfg_over_s;
            end else begin
                active_delay_r <= active_delay_r;
                cfg_err_r      <= 1'b1;
            end
        end else begin
            active_delay_r <= active_delay_r;
            cfg_err_r      <= 1'b0;
        end
    end

    // One-hot AND-OR tap select of stage active_delay (1-based).
    always_comb begin
        tap_valid_s = 1'b0;
        tap_tf_s    = '0;
        tap_mod_s   = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            tap_valid_s = tap_valid_s | (valid_r[k] & (active_delay_r == CW'(k + 1)));
            tap_tf_s    = tap_tf_s  | (tf_r[k]  & {TW{active_delay_r == CW'(k + 1)}});
            tap_mod_s   = tap_mod_s | (mod_r[k] & {DW{active_delay_r == CW'(k + 1)}});
        end
    end

    // Zero delay bypasses the stages; otherwise present the tapped stage.
    always_comb begin
        out_valid_s = 1'b0;
        tf_out_s    = '0;
        mod_out_s   = '0;
        if (active_delay_r == '0) begin
            out_valid_s = bus.in_valid & advance_s;
            tf_out_s    = bus.tf_in;
            mod_out_s   = bus.mod_in;
        end else begin
            out_valid_s = tap_valid_s;
            tf_out_s    = tap_tf_s;
            mod_out_s   = tap_mod_s;
        end
    end

    assign bus.out_valid    = out_valid_s;
    assign bus.tf_out       = tf_out_s;
    assign bus.mod_out      = mod_out_s;
    assign bus.busy         = busy_s;
    assign bus.active_delay = active_delay_r;
    assign bus.cfg_err      = cfg_err_r;

endmodule

// File: tb/tb_tf_delay_line.sv
// Directed bench for tf_delay_line. Accepted sets are pushed to a scoreboard
// tagged with the advance count at which they must reach the output; a small
// reference model tracks busy, active_delay and cfg_err from the driven inputs.
module tb_tf_delay_line;

    localparam int NUM_CH    = 16;
    localparam int DW        = 16;
    localparam int MAX_DEPTH = 8;
    localparam int CW        = 4;
    localparam int TW        = NUM_CH * DW;

    typedef struct {
        logic [TW-1:0] tf;
        logic [DW-1:0] md;
        int            due;
    } exp_t;

    logic clk;
    logic rst;

    tf_delay_line_if #(.NUM_CH(NUM_CH), .DW(DW), .CW(CW)) bus ();

    tf_delay_line #(
        .NUM_CH(NUM_CH), .DW(DW), .MAX_DEPTH(MAX_DEPTH),
        .DEFAULT_DELAY(3), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    exp_t                 sb[$];
    int                   total = 0;
    int                   bad   = 0;
    int                   adv   = 0;
    int                   m_d   = 3;
    logic [MAX_DEPTH-1:0] m_v   = '0;
    logic                 m_err = 1'b0;
    logic                 chk_zero = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] pat(input int n);
        logic [TW-1:0] p;
        for (int c = 0; c < NUM_CH; c++) begin
            p[c*DW +: DW] = 16'(16'h0100 * n + c);
        end
        return p;
    endfunction

    function automatic logic [TW-1:0] rep(input int v);
        return {NUM_CH{16'(v)}};
    endfunction

    task automatic drive(input logic v, input logic [TW-1:0] tf, input logic [DW-1:0] md);
        bus.in_valid = v;
        bus.tf_in    = tf;
        bus.mod_in   = md;
    endtask

    // One clock cycle: inputs are already driven (posedge+1); check at the
    // negedge, then apply the model update for the coming edge.
    task automatic tick();
        logic exp_v;
        logic busy_pre;
        if (bus.in_valid && !bus.stall && !bus.flush) begin
            sb.push_back('{tf: bus.tf_in, md: bus.mod_in, due: adv + m_d});
        end
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due < adv) void'(sb.pop_front());
        exp_v = (sb.size() > 0) && (sb[0].due == adv);
        chk("out_valid", TW'(bus.out_valid), TW'(exp_v));
        if (exp_v) begin
            chk("tf_out", bus.tf_out, sb[0].tf);
            chk("mod_out", TW'(bus.mod_out), TW'(sb[0].md));
        end else if (chk_zero) begin
            chk("tf_out_zero", bus.tf_out, TW'(0));
            chk("mod_out_zero", TW'(bus.mod_out), TW'(0));
        end
        chk("busy", TW'(bus.busy), TW'(|m_v));
        chk("active_delay", TW'(bus.active_delay), TW'(m_d));
        chk("cfg_err", TW'(bus.cfg_err), TW'(m_err));
        @(posedge clk);
        busy_pre = |m_v;
        m_err = bus.cfg_we & (busy_pre | bus.stall | (bus.delay_cfg > CW'(MAX_DEPTH)));
        if (bus.cfg_we && !busy_pre && !bus.stall) begin
            m_d = (bus.delay_cfg > CW'(MAX_DEPTH)) ? MAX_DEPTH : int'(bus.delay_cfg);
        end
        if (bus.flush) begin
            m_v = '0;
            sb.delete();
        end else if (!bus.stall) begin
            m_v = {m_v[MAX_DEPTH-2:0], bus.in_valid};
            adv++;
        end
        #1;
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic cfg(input int val);
        bus.cfg_we    = 1'b1;
        bus.delay_cfg = CW'(val);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.tf_in = '0; bus.mod_in = '0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.cfg_we = 1'b0; bus.delay_cfg = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", TW'(bus.out_valid), TW'(0));
        chk("rst_busy", TW'(bus.busy), TW'(0));
        chk("rst_tf_out", bus.tf_out, TW'(0));
        chk("rst_active_delay", TW'(bus.active_delay), TW'(3));
        chk("rst_cfg_err", TW'(bus.cfg_err), TW'(0));
        rst = 1'b1;

        // Default delay 3: ten consecutive sets, zero outputs until set 0 emerges
        chk_zero = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n == 3) chk_zero = 1'b0;
            drive(1'b1, pat(n), 16'(16'h7000 + n));
            tick();
        end
        chk_zero = 1'b0;
        idle(10);

        // Stall while value 2 is at the output; stalled inputs are dropped
        for (int v = 1; v <= 4; v++) begin
            drive(1'b1, rep(v), 16'(v)); tick();
        end
        drive(1'b1, rep(16'hEE), 16'hEE); bus.stall = 1'b1; tick();
        drive(1'b1, rep(16'hEF), 16'hEF); bus.stall = 1'b1; tick();
        drive(1'b1, rep(5), 16'd5); tick();
        drive(1'b1, rep(6), 16'd6); tick();
        idle(10);

        // Flush at delay 5 after four sets
        cfg(5);
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, pat(n + 32), 16'(n)); tick();
        end
        drive(1'b1, pat(40), 16'd40); bus.flush = 1'b1; tick();
        idle(8);

        // Reconfiguration guard
        cfg(3);
        drive(1'b1, pat(50), 16'd50); tick();
        cfg(1);                                  // rejected: busy
        idle(10);
        bus.stall = 1'b1; cfg(2);                // rejected: stall
        cfg(1);                                  // accepted
        drive(1'b1, pat(60), 16'd60); tick();
        drive(1'b1, pat(61), 16'd61); tick();
        idle(10);
        cfg(15);                                 // clamped to 8 with error
        idle(2);

        // Zero-delay bypass
        cfg(0);
        drive(1'b1, {pat(70)[TW-1:DW], 16'hABCD}, 16'h1234); tick();
        drive(1'b1, pat(71), 16'd71); bus.stall = 1'b1; tick();
        drive(1'b1, pat(72), 16'd72); bus.flush = 1'b1; tick();
        idle(10);

        // Asynchronous reset mid-stream
        cfg(5);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, pat(80 + n), 16'(80 + n)); tick();
        end
        idle(5);
        chk("pre_rst_busy", TW'(bus.busy), TW'(1));
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", TW'(bus.out_valid), TW'(0));
        chk("arst_busy", TW'(bus.busy), TW'(0));
        chk("arst_tf_out", bus.tf_out, TW'(0));
        chk("arst_mod_out", TW'(bus.mod_out), TW'(0));
        chk("arst_active_delay", TW'(bus.active_delay), TW'(3));
        chk("arst_cfg_err", TW'(bus.cfg_err), TW'(0));
        sb.delete();
        m_v = '0; m_d = 3; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, pat(90), 16'd90); tick();
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tf_delay_line.md
# tf_delay_line

Parametrised multi-channel twiddle-factor delay line: aligns NUM_CH twiddle factors plus the modulus sideband with the butterfly datapath by a run-time selectable latency of 0..MAX_DEPTH cycles. Adds valid tracking, a pipeline-wide stall, a flush, and a guarded delay-reconfiguration port. Sits between the twiddle ROM/generator and the butterfly array of each NTT stage.

## Interface
Parameters:
- NUM_CH, 16: number of twiddle channels.
- DW, `D_width: width of each twiddle and of the modulus.
- MAX_DEPTH, 8: maximum delay in cycles (>=1).
- DEFAULT_DELAY, 3: delay after reset (0..MAX_DEPTH).
- CW, $clog2(MAX_DEPTH+1): width of the delay config field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  tf_in/mod_in carry a valid set.
- tf_in  in  NUM_CH*DW  packed twiddles; channel c occupies bits [c*DW +: DW].
- mod_in  in  DW  modulus sideband.
- stall  in  1  hold all stages; input not accepted.
- flush  in  1  invalidate all in-flight entries.
- cfg_we  in  1  request to load delay_cfg.
- delay_cfg  in  CW  requested delay.
- out_valid  out  1  tf_out/mod_out valid.
- tf_out  out  NUM_CH*DW  delayed twiddles, same packing.
- mod_out  out  DW  delayed modulus.
- busy  out  1  any stage holds a valid entry.
- active_delay  out  CW  delay currently applied.
- cfg_err  out  1  one-cycle pulse: config rejected or clamped.

## Operation
- Storage: MAX_DEPTH stages, each {valid, NUM_CH twiddles, modulus}. Stage k (1-based) is the value presented k advances ago.
- Advance (stall=0, flush=0): stage1 <= {in_valid, tf_in, mod_in}; stage k <= stage k-1. Data shifts unconditionally; valid bits track validity.
- Stall (stall=1, flush=0): all stages hold; in_valid/tf_in/mod_in ignored (the set is dropped; upstream shares the stall).
- Flush (flush=1): all valid bits cleared next edge; data registers untouched; flush has priority over stall and advance; the input that cycle is dropped.
- Output select, D = active_delay: D>=1: {out_valid, tf_out, mod_out} = stage D (registered path, no logic after the flop mux beyond the tap select). D=0: combinational bypass, out_valid = in_valid & ~stall & ~flush, tf_out = tf_in, mod_out = mod_in.
- out_valid is not gated by stall for D>=1: a stalled output is re-presented unchanged.
- busy = OR of all MAX_DEPTH valid bits, including stages beyond D.
- Reconfiguration, on cfg_we=1:
  - If busy=0 and stall=0: active_delay <= min(delay_cfg, MAX_DEPTH) at the next edge. If delay_cfg > MAX_DEPTH, the value is clamped and cfg_err pulses.
  - Otherwise the request is ignored, active_delay is unchanged, and cfg_err pulses.
  - cfg_we together with flush: the flush applies, and the config is judged on the pre-flush busy value.
- Reset (rst=0, async): all valid bits 0, all data 0, active_delay=DEFAULT_DELAY, cfg_err=0. Outputs: out_valid=0, tf_out=0, mod_out=0, busy=0. Reset mid-stream discards all in-flight entries.

## Timing
- Latency = active_delay advancing cycles. Stall cycles add 1:1 to latency.
- Throughput: one set per non-stalled cycle at any delay.
- active_delay change is visible at the output on the edge after acceptance. Stale stages beyond the old tap are invalid by construction, because busy=0 is required.
- cfg_err is high for exactly one cycle after the offending request.
- busy falls on the MAX_DEPTH-th advance after the last valid input, or one edge after flush.

## Test plan
- Reset/default: release rst, drive 10 consecutive valid sets, channel c = 16'h100*n+c at cycle n -> outputs zero and out_valid=0 until cycle 3; set n appears exactly 3 cycles later, all 16 channels and modulus intact.
- Stall hold: D=3, stream values 1..6, assert stall for 2 cycles while value 2 is on tf_out -> value 2 held with out_valid=1 for 3 cycles; inputs during the stall are absent at the output; the rest of the sequence continues in order.
- Flush: D=5, inject 4 valid sets, flush on the cycle after the 4th -> out_valid stays 0 thereafter; busy=0 one edge later; data pins may be nonzero.
- Reconfig guard: busy=1, cfg_we with delay_cfg=1 -> cfg_err pulse, active_delay stays 3. After drain, delay_cfg=1 -> accepted, next input appears 1 cycle later. delay_cfg=15 (MAX_DEPTH=8) -> active_delay=8 with a cfg_err pulse.
- Bypass: D=0, in_valid=1, tf_in ch0=0xABCD -> same-cycle tf_out ch0=0xABCD, out_valid=1. Same with stall=1 -> out_valid=0.
- Async reset mid-stream: rst low between edges with busy=1 -> out_valid, busy, and data outputs drop to 0 immediately; active_delay returns to 3.
